// File: rtl/srl16_fifo_ctrl.sv
// Occupancy-counter controller for a first-word-fall-through FIFO whose storage is
// an external SRL16-style addressable shift-register column.
module srl16_fifo_ctrl #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WR_EN,
    input  logic       RD_EN,
    output logic       SRL_CE,
    output logic [3:0] SRL_A,
    output logic [4:0] COUNT,
    output logic       FULL,
    output logic       EMPTY,
    output logic       ALMOST_FULL,
    output logic       ALMOST_EMPTY,
    output logic       OVERFLOW,
    output logic       UNDERFLOW
);

    localparam int unsigned CW = 5;
    localparam int unsigned AW = 4;

    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [CW-1:0] w_count_nxt;

    // Status is decoded from the count register alone so it never glitches with requests
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == CW'(0));
    assign w_push_ok = WR_EN & ~w_full;
    assign w_pop_ok  = RD_EN & ~w_empty;

    // Push+pop leaves occupancy unchanged; the shift moves the oldest entry up one tap
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_overflow  <= WR_EN & w_full;
            r_underflow <= RD_EN & w_empty;
        end
    end

    // Shift enable is combinational so the SRL shifts on the edge that accepts the push
    assign SRL_CE       = w_push_ok & RST_N;
    assign SRL_A        = w_empty ? AW'(0) : AW'(r_count - CW'(1));
    assign COUNT        = r_count;
    assign FULL         = w_full;
    assign EMPTY        = w_empty;
    assign ALMOST_FULL  = (r_count >= CW'(AF_LEVEL));
    assign ALMOST_EMPTY = (r_count <= CW'(AE_LEVEL));
    assign OVERFLOW     = r_overflow;
    assign UNDERFLOW    = r_underflow;

endmodule

// File: doc/srl16_fifo_ctrl.md
SRL16_FIFO_CTRL -- requirements
Module: srl16_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: usable FIFO depth in entries; legal range 2..16.
REQ-002 Parameter AF_LEVEL, default 14: ALMOST_FULL asserts when COUNT >= AF_LEVEL.
REQ-003 Parameter AE_LEVEL, default 2: ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.
REQ-004 Port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port WR_EN, input, 1 bit: push request; data is presented on the external shift-register D pin in the same cycle.
REQ-007 Port RD_EN, input, 1 bit: pop request; the oldest entry is visible on the external shift-register Q while EMPTY=0.
REQ-008 Port SRL_CE, output, 1 bit: clock enable to the external shift-register column(s).
REQ-009 Port SRL_A, output, 4 bits: tap address to the external shift-register column(s) A3..A0.
REQ-010 Port COUNT, output, 5 bits: current occupancy, 0..DEPTH.
REQ-011 Port FULL, output, 1 bit: COUNT == DEPTH.
REQ-012 Port EMPTY, output, 1 bit: COUNT == 0.
REQ-013 Port ALMOST_FULL, output, 1 bit: COUNT >= AF_LEVEL.
REQ-014 Port ALMOST_EMPTY, output, 1 bit: COUNT <= AE_LEVEL.
REQ-015 Port OVERFLOW, output, 1 bit: one-cycle pulse for a rejected push.
REQ-016 Port UNDERFLOW, output, 1 bit: one-cycle pulse for a rejected pop.

Function
REQ-017 The block SHALL run first-word-fall-through: the oldest entry is valid on the external Q whenever EMPTY=0, with no read latency.
REQ-018 push_ok SHALL be WR_EN & ~FULL; a push while FULL is rejected even if a pop is accepted in the same cycle.
REQ-019 pop_ok SHALL be RD_EN & ~EMPTY.
REQ-020 SRL_CE SHALL be combinational: SRL_CE = push_ok & RST_N, so the shift happens on the same edge that accepts the push.
REQ-021 COUNT SHALL be the only occupancy register, updated as follows:
- push only: +1
- pop only: -1
- both, or neither: unchanged
REQ-022 COUNT SHALL never wrap: it never exceeds DEPTH and never goes below 0.
REQ-023 SRL_A SHALL be COUNT-1 when COUNT > 0, and 0 when COUNT == 0.
REQ-024 SRL_A SHALL derive only from the COUNT register (glitch-free within a cycle).
REQ-025 On a simultaneous push and pop, the shift moves the oldest entry up one tap while SRL_A holds; the next-oldest entry is then addressed, and this is correct behaviour.
REQ-026 FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY SHALL be decoded from the COUNT register only, never from WR_EN or RD_EN.
REQ-027 OVERFLOW SHALL be registered and SHALL assert for exactly one cycle after each cycle with WR_EN & FULL.
REQ-028 UNDERFLOW SHALL be registered and SHALL assert for exactly one cycle after each cycle with RD_EN & EMPTY.
REQ-029 Rejected requests SHALL change no state other than OVERFLOW and UNDERFLOW.
REQ-030 Contents of the external shift register are not reset; after reset they are don't-care because EMPTY=1.

Reset
REQ-031 While RST_N=0, the block SHALL hold, independent of CLK:
- COUNT=0, SRL_A=0, EMPTY=1, ALMOST_EMPTY=1
- FULL=0, ALMOST_FULL=0 (given AF_LEVEL>0)
- OVERFLOW=0, UNDERFLOW=0, SRL_CE=0
REQ-032 A reset asserted mid-operation SHALL discard all occupancy immediately; the first push after release behaves as a push into an empty FIFO.
REQ-033 Release of RST_N SHALL take effect at the first CLK rising edge with RST_N=1.

Verification
REQ-034 Fill: from reset, 16 pushes of D=0..15 with DEPTH=16 -> COUNT reaches 16, FULL=1, ALMOST_FULL first asserts when COUNT=14, SRL_A=15, Q=0.
REQ-035 Drain: from the full state, 16 pops -> Q sequence is 0,1,...,15, EMPTY=1 after the last pop, SRL_A=0, COUNT=0.
REQ-036 Simultaneous push/pop: with COUNT=5 holding 10..14, push 99 and pop in the same cycle -> COUNT stays 5, SRL_A stays 4, Q=11; later drain order is 11,12,13,14,99.
REQ-037 Overflow/underflow: WR_EN=1 at COUNT=16 -> next cycle OVERFLOW=1 for one cycle, COUNT=16, SRL_CE=0 in the request cycle. RD_EN=1 at COUNT=0 -> UNDERFLOW=1 for one cycle, COUNT=0.
REQ-038 Full plus push plus pop: at COUNT=16, WR_EN=RD_EN=1 -> pop accepted, push rejected, COUNT=15, OVERFLOW pulses.
REQ-039 Async reset: drop RST_N between CLK edges at COUNT=7 -> COUNT=0, EMPTY=1 and SRL_CE=0 immediately; after release, a single push gives COUNT=1, SRL_A=0, Q=pushed value.
